// File: rtl/leglite_pkg.sv
// Shared LEGLite definitions: datapath width, instruction-memory FSM states and the fetch NOP.
package leglite_pkg;

    localparam int unsigned LEG_WIDTH = 16;

    typedef enum logic {
        IM_LOAD = 1'b0,
        IM_RUN  = 1'b1
    } im_state_e;

    localparam logic [LEG_WIDTH-1:0] IM_NOP = 16'h0000;

    // A fetch is in range only when every byte-address bit above the word index is zero.
    function automatic logic fetch_hi_clear(input logic [15:0] iaddr, input int unsigned aw);
        return (iaddr >> (aw + 1)) == 16'h0000;
    endfunction

endpackage

// File: rtl/im_ram.sv
// Instruction storage: DEPTH x WIDTH words, one synchronous write port, one asynchronous read.
module im_ram #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    // No reset: the program image must survive a reset.
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/im_loadable.sv
// Loadable instruction memory: streams a program in over valid/ready, then releases the CPU
// and serves combinational fetches. A reload can be started at any time with ld_start_i.
module im_loadable
    import leglite_pkg::*;
#(
    parameter int unsigned WIDTH     = LEG_WIDTH,
    parameter int unsigned DEPTH     = 32,
    parameter int unsigned AW        = 5,
    parameter bit          BOOT_LOAD = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [15:0]      iaddr_i,
    output logic [WIDTH-1:0] idata_o,
    output logic             cpu_run_o,
    input  logic             ld_start_i,
    input  logic             ld_valid_i,
    input  logic [WIDTH-1:0] ld_data_i,
    input  logic             ld_last_i,
    output logic             ld_ready_o,
    output logic [AW:0]      ld_count_o,
    output logic [15:0]      ld_sum_o,
    output logic             ld_err_o
);

    localparam logic [AW:0] DepthCnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0] LastIdx  = (AW + 1)'(DEPTH - 1);
    localparam im_state_e   RstState = BOOT_LOAD ? IM_LOAD : IM_RUN;

    im_state_e       state_q, state_d;
    logic [AW:0]     count_q, count_d;
    logic [15:0]     sum_q, sum_d;
    logic            err_q, err_d;
    logic            mem_we;
    logic            xfer;
    logic            in_range;
    logic [15:0]     data_ext;
    logic [WIDTH-1:0] rdata;

    assign ld_ready_o = (state_q == IM_LOAD);
    assign cpu_run_o  = (state_q == IM_RUN);
    assign ld_count_o = count_q;
    assign ld_sum_o   = sum_q;
    assign ld_err_o   = err_q;

    assign xfer     = ld_valid_i & ld_ready_o;
    assign data_ext = 16'(ld_data_i);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sum_d   = sum_q;
        err_d   = err_q;
        mem_we  = 1'b0;
        unique case (state_q)
            IM_LOAD: begin
                // A restart wins over any word offered in the same cycle.
                if (ld_start_i) begin
                    count_d = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end else if (xfer) begin
                    mem_we  = 1'b1;
                    count_d = count_q + 1'b1;
                    sum_d   = sum_q + data_ext;
                    if (ld_last_i) begin
                        state_d = IM_RUN;
                    end else if (count_q == LastIdx) begin
                        state_d = IM_RUN;
                        err_d   = 1'b1;
                    end
                end
            end
            IM_RUN: begin
                if (ld_start_i) begin
                    state_d = IM_LOAD;
                    count_d = '0;
                    sum_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IM_LOAD;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RstState;
            count_q <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
        end
    end

    im_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (count_q[AW-1:0]),
        .wdata_i (ld_data_i),
        .raddr_i (iaddr_i[AW:1]),
        .rdata_o (rdata)
    );

    // Guard the index too, in case DEPTH is not a power of two.
    assign in_range = fetch_hi_clear(iaddr_i, AW) && ({1'b0, iaddr_i[AW:1]} < DepthCnt);

    always_comb begin
        idata_o = WIDTH'(IM_NOP);
        if (cpu_run_o && in_range) begin
            idata_o = rdata;
        end
    end

endmodule

// File: tb/tb_im_loadable.sv
// Directed bench for im_loadable: a behavioural loader/memory model checked every cycle,
// plus hand-computed literal expectations at key points of each scenario.
module tb_im_loadable;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] iaddr = '0;
    logic [15:0] idata;
    logic        cpu_run;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [15:0] ld_data = '0;
    logic        ld_last = 1'b0;
    logic        ld_ready;
    logic [5:0]  ld_count;
    logic [15:0] ld_sum;
    logic        ld_err;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    im_loadable #(
        .WIDTH     (16),
        .DEPTH     (32),
        .AW        (5),
        .BOOT_LOAD (1'b1)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .iaddr_i    (iaddr),
        .idata_o    (idata),
        .cpu_run_o  (cpu_run),
        .ld_start_i (ld_start),
        .ld_valid_i (ld_valid),
        .ld_data_i  (ld_data),
        .ld_last_i  (ld_last),
        .ld_ready_o (ld_ready),
        .ld_count_o (ld_count),
        .ld_sum_o   (ld_sum),
        .ld_err_o   (ld_err)
    );

    // Behavioural model: program words, loaded flag, counters.
    logic [15:0] m_mem [32];
    bit          m_run = 1'b0;
    int          m_cnt = 0;
    logic [15:0] m_sum = '0;
    bit          m_err = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            m_sum <= '0;
            m_err <= 1'b0;
        end else if (ld_start) begin
            m_run <= 1'b0;
            m_cnt <= 0;
            m_sum <= '0;
            m_err <= 1'b0;
        end else if (!m_run && ld_valid) begin
            m_mem[m_cnt] <= ld_data;
            m_cnt <= m_cnt + 1;
            m_sum <= m_sum + ld_data;
            if (ld_last) begin
                m_run <= 1'b1;
            end else if (m_cnt == 31) begin
                m_run <= 1'b1;
                m_err <= 1'b1;
            end
        end
    end

    function automatic logic [15:0] exp_idata();
        if (!m_run) return 16'h0000;
        if (iaddr >= 16'h0040) return 16'h0000;
        return m_mem[iaddr[5:1]];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && chk_en) begin
            check("m_ready", 32'(ld_ready), 32'(!m_run));
            check("m_run", 32'(cpu_run), 32'(m_run));
            check("m_count", 32'(ld_count), 32'(m_cnt));
            check("m_sum", 32'(ld_sum), 32'(m_sum));
            check("m_err", 32'(ld_err), 32'(m_err));
            check("m_idata", 32'(idata), 32'(exp_idata()));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [15:0] d, input logic l);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = l;
        cyc();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = '0;
    endtask

    task automatic pulse_start();
        ld_start = 1'b1;
        cyc();
        ld_start = 1'b0;
    endtask

    task automatic peek(input string name, input logic [15:0] a, input logic [15:0] exp);
        iaddr = a;
        #1;
        check(name, 32'(idata), 32'(exp));
    endtask

    task automatic reset_state(input string tag);
        check({tag, "_ready"}, 32'(ld_ready), 32'd1);
        check({tag, "_run"}, 32'(cpu_run), 32'd0);
        check({tag, "_count"}, 32'(ld_count), 32'd0);
        check({tag, "_sum"}, 32'(ld_sum), 32'd0);
        check({tag, "_err"}, 32'(ld_err), 32'd0);
        check({tag, "_idata"}, 32'(idata), 32'd0);
    endtask

    logic [15:0] prog1 [9] = '{16'hC707, 16'h1111, 16'h2222, 16'h3333, 16'h4444,
                               16'h5555, 16'h6666, 16'h7777, 16'hA3C7};
    logic [15:0] prog2 [4] = '{16'h8000, 16'h9000, 16'h7001, 16'h0FFF};

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_state("rst");
        #2 rst_n = 1'b1;
        chk_en = 1'b1;
        cyc();

        // 1: nine words back-to-back, last on the ninth.
        for (int i = 0; i < 9; i++) send(prog1[i], i == 8);
        iaddr = 16'h000E;
        @(negedge clk);
        check("t1_run", 32'(cpu_run), 32'd1);
        check("t1_count", 32'(ld_count), 32'd9);
        check("t1_sum", 32'(ld_sum), 32'h48AA);
        check("t1_word7", 32'(idata), 32'h7777);
        cyc();

        // 2: valid toggles; a stray ld_last on an idle cycle must be ignored.
        pulse_start();
        check("t2_cleared", 32'(ld_count), 32'd0);
        for (int i = 0; i < 8; i++) begin
            ld_valid = (i % 2 == 0);
            ld_data  = ld_valid ? prog2[i / 2] : 16'hFFFF;
            ld_last  = (i == 1) || (i == 6);
            cyc();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        @(negedge clk);
        check("t2_count", 32'(ld_count), 32'd4);
        check("t2_sum", 32'(ld_sum), 32'h9000);
        check("t2_run", 32'(cpu_run), 32'd1);
        cyc();

        // 3: full depth without ld_last, then an extra word offered in RUN.
        pulse_start();
        for (int i = 0; i < 32; i++) send(16'h1000 + 16'(i), 1'b0);
        ld_valid = 1'b1;
        ld_data  = 16'hDEAD;
        cyc();
        cyc();
        ld_valid = 1'b0;
        iaddr = 16'h003E;
        @(negedge clk);
        check("t3_count", 32'(ld_count), 32'd32);
        check("t3_err", 32'(ld_err), 32'd1);
        check("t3_ready", 32'(ld_ready), 32'd0);
        check("t3_run", 32'(cpu_run), 32'd1);
        check("t3_word31", 32'(idata), 32'h101F);
        cyc();

        // 4: range checks and byte-offset bit.
        peek("t4_idx32", 16'h0040, 16'h0000);
        peek("t4_fff0", 16'hFFF0, 16'h0000);
        peek("t4_odd", 16'h0003, 16'h1001);
        peek("t4_even", 16'h0002, 16'h1001);
        cyc();

        // 5: reload two words from RUN.
        pulse_start();
        check("t5_count", 32'(ld_count), 32'd0);
        check("t5_err", 32'(ld_err), 32'd0);
        check("t5_sum", 32'(ld_sum), 32'd0);
        send(16'hAAAA, 1'b0);
        send(16'h5555, 1'b1);
        peek("t5_w0", 16'h0000, 16'hAAAA);
        peek("t5_w1", 16'h0002, 16'h5555);
        peek("t5_w2", 16'h0004, 16'h1002);
        peek("t5_w31", 16'h003E, 16'h101F);
        check("t5_sumfin", 32'(ld_sum), 32'hFFFF);
        cyc();

        // 6: reset in the middle of a load.
        pulse_start();
        for (int i = 0; i < 4; i++) send(16'h0E01 + 16'(i), 1'b0);
        #1 rst_n = 1'b0;
        #1 reset_state("t6_rst");
        #4 rst_n = 1'b1;
        cyc();
        check("t6_ready", 32'(ld_ready), 32'd1);
        send(16'h0E01, 1'b1);
        peek("t6_w0", 16'h0000, 16'h0E01);
        peek("t6_w1", 16'h0002, 16'h0E02);
        peek("t6_w2", 16'h0004, 16'h0E03);
        peek("t6_w3", 16'h0006, 16'h0E04);
        check("t6_count", 32'(ld_count), 32'd1);
        check("t6_run", 32'(cpu_run), 32'd1);
        cyc();

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
